// File: rtl/gfx_geom_tx.sv
`default_nettype none
// ============================================================================
// Module   : gfx_geom_tx
// Purpose  : Serializes accepted triangles into 7-word geometry stream packets
//            (header + six coordinates) with backpressure and back-to-back
//            packet support.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_geom_tx #(
    parameter int TAG_BITS = 16
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                tri_valid,
    output logic                tri_ready,
    input  logic [31:0]         tri_x [3],
    input  logic [31:0]         tri_y [3],
    input  logic [TAG_BITS-1:0] tri_tag,
    output logic [31:0]         geom_tdata,
    output logic                geom_tlast,
    output logic                geom_tvalid,
    input  logic                geom_tready,
    output logic [31:0]         pkt_count
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SEND  = 1'b1;
    localparam logic [2:0] c_LAST_BEAT = 3'd6;

    logic [0:0]          r_state;
    logic [2:0]          r_beat;
    logic [15:0]         r_seq;
    logic [31:0]         r_pkt_count;
    logic [31:0]         r_x [3];
    logic [31:0]         r_y [3];
    logic [TAG_BITS-1:0] r_tag;

    logic        w_send;
    logic        w_last;
    logic        w_xfer;
    logic        w_accept;
    logic [15:0] w_tag_ext;
    logic [31:0] w_word;

    assign w_send   = (r_state == c_ST_SEND);
    assign w_last   = (r_beat == c_LAST_BEAT);
    assign w_xfer   = w_send && geom_tready;
    assign w_accept = tri_valid && tri_ready;

    // Ready is forced low during reset so a simultaneous offer is never taken.
    always_comb begin
        tri_ready = 1'b0;
        if (!srst) begin
            if (!w_send) tri_ready = 1'b1;
            else         tri_ready = geom_tready && w_last;
        end
    end

    always_comb begin
        w_tag_ext                 = '0;
        w_tag_ext[TAG_BITS-1:0]   = r_tag;
    end

    always_comb begin
        case (r_beat)
            3'd0:    w_word = {r_seq, w_tag_ext};
            3'd1:    w_word = r_x[0];
            3'd2:    w_word = r_y[0];
            3'd3:    w_word = r_x[1];
            3'd4:    w_word = r_y[1];
            3'd5:    w_word = r_x[2];
            default: w_word = r_y[2];
        endcase
    end

    // Outputs derive only from registers, so they hold steady across stalls.
    assign geom_tvalid = w_send;
    assign geom_tdata  = w_send ? w_word : 32'd0;
    assign geom_tlast  = w_send && w_last;
    assign pkt_count   = r_pkt_count;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= c_ST_IDLE;
            r_beat      <= 3'd0;
            r_seq       <= 16'd0;
            r_pkt_count <= 32'd0;
            r_tag       <= '0;
            for (int i = 0; i < 3; i++) begin
                r_x[i] <= 32'd0;
                r_y[i] <= 32'd0;
            end
        end else begin
            if (w_accept) begin
                r_tag <= tri_tag;
                for (int i = 0; i < 3; i++) begin
                    r_x[i] <= tri_x[i];
                    r_y[i] <= tri_y[i];
                end
            end

            if (!w_send) begin
                if (w_accept) begin
                    r_state <= c_ST_SEND;
                    r_beat  <= 3'd0;
                end
            end else if (w_xfer) begin
                if (r_beat == 3'd0) r_seq <= r_seq + 16'd1;
                if (!w_last) begin
                    r_beat <= r_beat + 3'd1;
                end else begin
                    r_pkt_count <= r_pkt_count + 32'd1;
                    r_beat      <= 3'd0;
                    if (!tri_valid) r_state <= c_ST_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gfx_geom_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_geom_tx
// Purpose  : Directed self-checking bench for the geometry packet transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_geom_tx;

    logic        clk = 1'b0;
    logic        srst;
    logic        tri_valid;
    logic        tri_ready;
    logic [31:0] tri_x [3];
    logic [31:0] tri_y [3];
    logic [15:0] tri_tag;
    logic [31:0] geom_tdata;
    logic        geom_tlast;
    logic        geom_tvalid;
    logic        geom_tready;
    logic [31:0] pkt_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gfx_geom_tx #(.TAG_BITS(16)) dut (
        .clk         (clk),
        .srst        (srst),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .tri_x       (tri_x),
        .tri_y       (tri_y),
        .tri_tag     (tri_tag),
        .geom_tdata  (geom_tdata),
        .geom_tlast  (geom_tlast),
        .geom_tvalid (geom_tvalid),
        .geom_tready (geom_tready),
        .pkt_count   (pkt_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_tri(input logic [15:0] tag, input logic [31:0] xa, ya, xb, yb, xc, yc);
        @(negedge clk);
        tri_tag = tag;
        tri_x[0] = xa; tri_y[0] = ya;
        tri_x[1] = xb; tri_y[1] = yb;
        tri_x[2] = xc; tri_y[2] = yc;
        tri_valid   = 1'b1;
        geom_tready = 1'b1;
        #1;
        chk("accept_ready", {31'd0, tri_ready}, 32'd1);
    endtask

    // Receives one packet starting the cycle after acceptance.
    task automatic collect(input string name, input logic [31:0] ew [7], input bit bp, input bit scr);
        int          idx   = 0;
        int          cyc   = 0;
        logic        stall = 1'b0;
        logic [31:0] pd    = '0;
        logic        pl    = 1'b0;
        while (idx < 7 && cyc < 200) begin
            @(negedge clk);
            tri_valid = 1'b0;
            if (scr) begin
                for (int i = 0; i < 3; i++) begin
                    tri_x[i] = $urandom;
                    tri_y[i] = $urandom;
                end
                tri_tag = 16'($urandom);
            end
            geom_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cyc++;
            if (cyc == 1)    chk({name, "_latency_tvalid"}, {31'd0, geom_tvalid}, 32'd1);
            else if (idx > 0) chk({name, "_tvalid_hold"}, {31'd0, geom_tvalid}, 32'd1);
            if (stall) begin
                chk({name, "_stall_tdata"}, geom_tdata, pd);
                chk({name, "_stall_tlast"}, {31'd0, geom_tlast}, {31'd0, pl});
            end
            if (geom_tvalid && geom_tready) begin
                chk({name, "_tdata"}, geom_tdata, ew[idx]);
                chk({name, "_tlast"}, {31'd0, geom_tlast}, (idx == 6) ? 32'd1 : 32'd0);
                idx++;
            end
            stall = geom_tvalid && !geom_tready;
            pd    = geom_tdata;
            pl    = geom_tlast;
        end
        chk({name, "_beats"}, 32'(idx), 32'd7);
        if (!bp) chk({name, "_cycles"}, 32'(cyc), 32'd7);
    endtask

    task automatic check_idle(input string name, input logic [31:0] exp_count);
        @(negedge clk);
        tri_valid   = 1'b0;
        geom_tready = 1'b1;
        #1;
        chk({name, "_pkt_count"}, pkt_count, exp_count);
        chk({name, "_tri_ready"}, {31'd0, tri_ready}, 32'd1);
        chk({name, "_tvalid_idle"}, {31'd0, geom_tvalid}, 32'd0);
    endtask

    logic [31:0] ew [7];
    logic [31:0] bw [21];
    logic [15:0] btag [3];
    int          k, n, cyc, first_c, last_c;

    initial begin
        srst = 1'b1; tri_valid = 1'b0; geom_tready = 1'b0; tri_tag = '0;
        for (int i = 0; i < 3; i++) begin tri_x[i] = '0; tri_y[i] = '0; end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tvalid", {31'd0, geom_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, geom_tlast}, 32'd0);
        chk("rst_tdata", geom_tdata, 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_tri_ready_in_reset", {31'd0, tri_ready}, 32'd0);
        srst = 1'b0;
        #1;
        chk("rst_tri_ready_after", {31'd0, tri_ready}, 32'd1);

        // Single packet
        send_tri(16'h00AB, 1, 2, 3, 4, 5, 6);
        ew = '{32'h0000_00AB, 1, 2, 3, 4, 5, 6};
        collect("single", ew, 1'b0, 1'b0);
        check_idle("single", 32'd1);

        // Backpressure, seq now 1
        send_tri(16'h00AB, 1, 2, 3, 4, 5, 6);
        ew = '{32'h0001_00AB, 1, 2, 3, 4, 5, 6};
        collect("bp", ew, 1'b1, 1'b0);
        check_idle("bp", 32'd2);

        // Input isolation, seq now 2
        send_tri(16'h1234, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5);
        ew = '{32'h0002_1234, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        collect("iso", ew, 1'b1, 1'b1);
        check_idle("iso", 32'd3);

        // Reset during beat 3
        send_tri(16'h0077, 7, 8, 9, 10, 11, 12);
        repeat (3) begin @(negedge clk); tri_valid = 1'b0; geom_tready = 1'b1; end
        @(negedge clk);
        #1;
        chk("rstmid_beat3", geom_tdata, 32'd9);
        srst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_tvalid", {31'd0, geom_tvalid}, 32'd0);
        chk("rstmid_tlast", {31'd0, geom_tlast}, 32'd0);
        chk("rstmid_pkt_count", pkt_count, 32'd0);
        chk("rstmid_tri_ready", {31'd0, tri_ready}, 32'd0);
        srst = 1'b0;

        // Back-to-back: three triangles with tri_valid held, headers seq 0,1,2
        btag = '{16'h0010, 16'h0011, 16'h0012};
        for (int t = 0; t < 3; t++) begin
            bw[t*7] = {16'(t), btag[t]};
            for (int j = 1; j < 7; j++) bw[t*7+j] = 32'(t*256 + j);
        end
        k = 0; n = 0; cyc = 0; first_c = -1; last_c = -1;
        while (n < 21 && cyc < 100) begin
            @(negedge clk);
            tri_valid   = (k < 3);
            geom_tready = 1'b1;
            if (k < 3) begin
                tri_tag = btag[k];
                for (int i = 0; i < 3; i++) begin
                    tri_x[i] = 32'(k*256 + 2*i + 1);
                    tri_y[i] = 32'(k*256 + 2*i + 2);
                end
            end
            #1;
            cyc++;
            if (geom_tvalid && geom_tready) begin
                chk("b2b_tdata", geom_tdata, bw[n]);
                chk("b2b_tlast", {31'd0, geom_tlast}, (n % 7 == 6) ? 32'd1 : 32'd0);
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                n++;
            end
            if (tri_valid && tri_ready) k++;
        end
        chk("b2b_beats", 32'(n), 32'd21);
        chk("b2b_span", 32'(last_c - first_c + 1), 32'd21);
        check_idle("b2b", 32'd3);

        // Sequence wrap
        force dut.r_seq = 16'hFFFF;
        #1;
        release dut.r_seq;
        send_tri(16'h0055, 21, 22, 23, 24, 25, 26);
        ew = '{32'hFFFF_0055, 21, 22, 23, 24, 25, 26};
        collect("wrap0", ew, 1'b0, 1'b0);
        check_idle("wrap0", 32'd4);
        send_tri(16'h0066, 31, 32, 33, 34, 35, 36);
        ew = '{32'h0000_0066, 31, 32, 33, 34, 35, 36};
        collect("wrap1", ew, 1'b0, 1'b0);
        check_idle("wrap1", 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
